// File: rtl/synth_period_meter.sv
// -----------------------------------------------------------------------------
// synth_period_meter
//
// Measures a free-running square wave (the synth tone). The bench and debug
// logic use the results as numbers to compare against expected note
// frequencies. The tone is synchronised into clk. The meter reports, in clk
// cycles:
//   - the rising-edge-to-rising-edge distance (period)
//   - the number of high samples within that period (high_time)
// It also flags silence when no rising edge arrives for timeout_cycles.
//
// Handshake: valid is a push-only strobe with no ready. It is high for exactly
// one clk cycle whenever period/high_time/meas_count take a new measurement.
// Consumers must sample on that cycle. The outputs then hold until the next
// strobe or a timeout.
//
// Ports
//   clk         system clock; all logic on rising edge
//   reset       asynchronous, active-low; 0 clears all state
//   sig_in      tone input, asynchronous to clk
//   period      last rise-to-rise distance in clk cycles
//   high_time   high cycles within that period
//   valid       one-cycle strobe on each new measurement
//   silent      1 = no complete period since reset/timeout
//   meas_count  completed measurements, wraps 255 -> 0
//   fsm_state   debug view of the FSM: 0 = WAIT_FIRST, 1 = MEASURE
// -----------------------------------------------------------------------------
module synth_period_meter #(
  parameter int clk_freq       = 2_000_000,
  parameter int cnt_width      = 20,
  parameter int timeout_cycles = 200_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sig_in,
  output logic [cnt_width-1:0] period,
  output logic [cnt_width-1:0] high_time,
  output logic                 valid,
  output logic                 silent,
  output logic [7:0]           meas_count,
  output logic                 fsm_state
);

  typedef enum logic [0:0] {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } state_t;

  // clk_freq only documents the relationship between timeout_cycles and wall
  // time. A non-positive frequency, or a timeout the counter cannot reach,
  // is a broken configuration. In that case the timeout path stays disabled
  // rather than firing at an arbitrary count.
  localparam bit params_ok = (clk_freq > 0) &&
                             (longint'(timeout_cycles) < ((longint'(1) << cnt_width) - 1));

  localparam logic [cnt_width-1:0] timeout_val = cnt_width'(timeout_cycles);
  localparam logic [cnt_width-1:0] cnt_one     = cnt_width'(1);
  localparam logic [cnt_width-1:0] cnt_max     = '1;

  state_t               state;
  logic                 s1;
  logic                 s2;
  logic                 prev;
  logic [cnt_width-1:0] cnt;
  logic [cnt_width-1:0] hcnt;

  logic                 rise;
  logic                 timeout_hit;
  logic [cnt_width-1:0] cnt_inc;
  logic [cnt_width-1:0] hcnt_inc;

  // Both edges pass through the same two synchroniser stages. The latency
  // therefore cancels out of period and high_time.
  assign rise        = s2 & ~prev;
  assign timeout_hit = params_ok && (cnt == timeout_val);

  // Saturating increments: a stuck counter reads all-ones and never wraps
  // back to a small, plausible-looking value.
  assign cnt_inc  = (cnt  == cnt_max) ? cnt  : cnt  + cnt_one;
  assign hcnt_inc = (hcnt == cnt_max) ? hcnt : hcnt + cnt_one;

  assign fsm_state = (state == MEASURE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_FIRST;
      s1         <= 1'b0;
      s2         <= 1'b0;
      prev       <= 1'b0;
      cnt        <= '0;
      hcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      valid      <= 1'b0;
      silent     <= 1'b1;
      meas_count <= '0;
    end else begin
      s1    <= sig_in;
      s2    <= s1;
      prev  <= s2;
      valid <= 1'b0;

      case (state)
        WAIT_FIRST: begin
          // The first rise only arms the meter. No earlier edge exists to
          // measure from, so it produces no output.
          if (rise) begin
            cnt   <= cnt_one;
            hcnt  <= cnt_one;
            state <= MEASURE;
          end
        end

        MEASURE: begin
          // A rise takes priority over a coincident timeout. The period just
          // completed is still legitimate.
          if (rise) begin
            period     <= cnt;
            high_time  <= hcnt;
            valid      <= 1'b1;
            silent     <= 1'b0;
            meas_count <= meas_count + 8'd1;
            cnt        <= cnt_one;
            hcnt       <= cnt_one;
          end else if (timeout_hit) begin
            state     <= WAIT_FIRST;
            silent    <= 1'b1;
            period    <= '0;
            high_time <= '0;
          end else begin
            cnt <= cnt_inc;
            // hcnt freezes from the falling edge until the next rise. Gating
            // on s2 covers this, so no separate fall detector is needed.
            if (s2) begin
              hcnt <= hcnt_inc;
            end
          end
        end

        default: state <= WAIT_FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_synth_period_meter.sv
// -----------------------------------------------------------------------------
// tb_synth_period_meter
//
// Directed bench for synth_period_meter. Tone stimulus pushes the measurement
// that each rising edge is expected to complete. A negedge monitor pops one
// entry per valid strobe and compares it. Point checks cover:
//   - reset values
//   - timeout timing
//   - meas_count wrap
// -----------------------------------------------------------------------------
module tb_synth_period_meter;

  localparam int W = 20;
  localparam int T = 3000;  // shortened timeout keeps the run small

  logic         clk;
  logic         reset;
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         silent;
  logic [7:0]   meas_count;
  logic         fsm_state;

  synth_period_meter #(
    .clk_freq      (2_000_000),
    .cnt_width     (W),
    .timeout_cycles(T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .silent    (silent),
    .meas_count(meas_count),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required below 5000000", $time);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [2*W+7:0] exp_q[$];
  logic [7:0]     exp_count;
  bit             armed;
  int             last_p;
  int             last_h;
  int             checks = 0;
  int             passed = 0;
  int             last_valid_cyc = 0;
  bit             watch_silent = 0;
  bit             silent_glitch = 0;

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic model_clear();
    armed     = 1'b0;
    exp_count = 8'd0;
    exp_q.delete();
  endtask

  // A rise completes the previous period only if the meter was already armed.
  task automatic push_rise(input int p, input int h);
    if (armed) begin
      exp_count = exp_count + 8'd1;
      exp_q.push_back({W'(last_p), W'(last_h), exp_count});
    end
    armed  = 1'b1;
    last_p = p;
    last_h = h;
  endtask

  // ---------------- driver ----------------
  // Entered and left at #1 after a posedge. Rising edges are exactly p
  // clocks apart, and each high phase is sampled on exactly h clocks.
  task automatic tone(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      push_rise(p, h);
      repeat (h) @(posedge clk);
      #1 sig_in = 1'b0;
      repeat (p - h) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_int({tag, "_period"},     int'(period),     0);
    check_int({tag, "_high_time"},  int'(high_time),  0);
    check_int({tag, "_valid"},      int'(valid),      0);
    check_int({tag, "_silent"},     int'(silent),     1);
    check_int({tag, "_meas_count"}, int'(meas_count), 0);
    check_int({tag, "_state"},      int'(fsm_state),  0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset && valid) begin
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: got period=%0d high=%0d count=%0d, required no strobe",
                 period, high_time, meas_count);
      end else begin
        logic [2*W+7:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({period, high_time, meas_count} === e) passed++;
        else $display("FAIL measurement: got period=%0d high=%0d count=%0d, required period=%0d high=%0d count=%0d",
                      period, high_time, meas_count, e[2*W+7:W+8], e[W+7:8], e[7:0]);
      end
    end
    if (watch_silent && silent) silent_glitch = 1'b1;
  end

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b0;
    sig_in = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // 1: idle low well beyond the timeout
    repeat (5000) @(posedge clk);
    #1;
    check_int("t1_silent",     int'(silent),     1);
    check_int("t1_period",     int'(period),     0);
    check_int("t1_meas_count", int'(meas_count), 0);
    check_int("t1_state",      int'(fsm_state),  0);

    // 2: period 1000, high 500, five rises -> four measurements
    tone(1000, 500, 5);
    check_int("t2_meas_count", int'(meas_count), 4);

    // 3: tone change; must stay non-silent throughout
    watch_silent = 1'b1;
    tone(454, 100, 3);
    watch_silent = 1'b0;
    check_int("t3_no_silent", int'(silent_glitch), 0);

    // 4: stop low -> silent exactly T cycles after the last measuring rise
    begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 2 * T; k++) begin
        @(negedge clk);
        if (silent) begin
          got = 1'b1;
          break;
        end
      end
      check_int("t4_silent_seen", int'(got), 1);
      check_int("t4_timeout_delay", cyc - last_valid_cyc, T);
    end
    check_int("t4_period",     int'(period),     0);
    check_int("t4_high_time",  int'(high_time),  0);
    check_int("t4_meas_count", int'(meas_count), int'(exp_count));
    check_int("t4_state",      int'(fsm_state),  0);
    armed = 1'b0;
    @(posedge clk);
    #1;
    tone(200, 100, 2);  // first rise only re-arms
    check_int("t4_drained", exp_q.size(), 0);

    // 5: sig_in high across reset release arms the meter
    reset  = 1'b0;
    sig_in = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("t5_reset");
    reset = 1'b1;
    push_rise(200, 100);  // release acts as the arming rise
    repeat (100) @(posedge clk);
    #1 sig_in = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    tone(200, 100, 3);
    check_int("t5_meas_count", int'(meas_count), 3);

    // 6: reset mid-period, then 260 measurements -> meas_count wraps to 4
    sig_in = 1'b1;
    push_rise(300, 150);
    repeat (120) @(posedge clk);
    #1 reset = 1'b0;
    sig_in = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("t6_reset");
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tone(300, 150, 5);
    tone(40, 20, 256);
    repeat (10) @(posedge clk);
    #1;
    check_int("t6_meas_count_wrap", int'(meas_count), 4);
    check_int("t6_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
